// File: rtl/alu_shift_sequencer_if.sv
// alu_shift_sequencer_if: command, shift-unit and result signals of the shift sequencer.
// The slave modport is the sequencer's view. The master modport is the surrounding ALU/environment.
interface alu_shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] su_A;
  logic [WIDTH-1:0] su_B;
  logic [1:0]       su_fun;
  logic             su_enable;
  logic [WIDTH-1:0] su_out;
  logic             su_flag;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, su_out, su_flag, res_ready,
    input  cmd_ready, su_A, su_B, su_fun, su_enable, res_valid, res_data, res_zero
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, su_out, su_flag, res_ready,
    output cmd_ready, su_A, su_B, su_fun, su_enable, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: iterates a 1-bit registered shift unit to perform logical shifts of 0..WIDTH positions.
module alu_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic reset,
  alu_shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_clamp;
  logic             dir_q, dir_d;
  logic             cmd_ready_q, su_enable_q, res_valid_q;
  assign cnt_clamp = (bus.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cmd_count;
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        work_d  = bus.cmd_data;
        dir_d   = bus.cmd_dir;
        cnt_d   = cnt_clamp;
        state_d = (cnt_clamp == '0) ? DONE : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.su_flag) begin
        work_d  = bus.su_out;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? DONE : ISSUE;
      end
      DONE: state_d = bus.res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // Handshake outputs are registered from the next-state decode so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      su_enable_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      cmd_ready_q <= (state_d == IDLE);
      su_enable_q <= (state_d == ISSUE);
      res_valid_q <= (state_d == DONE);
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.su_A      = work_q;
  assign bus.su_B      = '0;
  assign bus.su_fun    = {1'b0, dir_q};
  assign bus.su_enable = su_enable_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = work_q;
  assign bus.res_zero  = ~|work_q;
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: table-driven directed checks of the shift sequencer against a behavioural 1-bit shift unit.
module tb_alu_shift_sequencer;
  localparam int W = 16;
  localparam int C = 5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] a_log[$];
  logic [1:0]   f_log[$];
  always #5 clk = ~clk;
  alu_shift_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus();
  alu_shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  // Registered 1-bit shift unit sharing the sequencer's reset
  always @(posedge clk) begin
    if (!reset) begin
      bus.su_flag <= 1'b0;
      bus.su_out  <= '0;
    end else begin
      bus.su_flag <= bus.su_enable;
      if (bus.su_enable) bus.su_out <= bus.su_fun[0] ? bus.su_A << 1 : bus.su_A >> 1;
    end
  end
  always @(posedge clk) if (reset && bus.su_enable) begin
    a_log.push_back(bus.su_A);
    f_log.push_back(bus.su_fun);
  end
  typedef struct {
    logic [W-1:0] d;
    logic         dr;
    logic [C-1:0] c;
    logic [W-1:0] ed;
    logic         ez;
    int           el;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [W-1:0] d, input logic dr, input logic [C-1:0] c, output int lat);
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_data  = d;
    bus.cmd_dir   = dr;
    bus.cmd_count = c;
    bus.cmd_valid = 1'b1;
    a_log.delete();
    f_log.delete();
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic ack;
    @(negedge clk) bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask
  initial begin
    int lat;
    logic [W-1:0] a;
    vecs[0] = '{16'h0001, 1'b1, 5'd3,  16'h0008, 1'b0, 6};
    vecs[1] = '{16'h8000, 1'b0, 5'd15, 16'h0001, 1'b0, 30};
    vecs[2] = '{16'hA5A5, 1'b1, 5'd0,  16'hA5A5, 1'b0, 0};
    vecs[3] = '{16'hFFFF, 1'b1, 5'd20, 16'h0000, 1'b1, 32};
    vecs[4] = '{16'h1234, 1'b0, 5'd4,  16'h0123, 1'b0, 8};
    vecs[5] = '{16'h00F0, 1'b1, 5'd16, 16'h0000, 1'b1, 32};
    vecs[6] = '{16'h0000, 1'b0, 5'd0,  16'h0000, 1'b1, 0};
    vecs[7] = '{16'h8001, 1'b1, 5'd31, 16'h0000, 1'b1, 32};
    vecs[8] = '{16'h00FF, 1'b1, 5'd8,  16'hFF00, 1'b0, 16};
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_res_data", {16'b0, bus.res_data}, 32'd0);
    chk("rst_res_zero", {31'b0, bus.res_zero}, 32'd1);
    chk("rst_su_enable", {31'b0, bus.su_enable}, 32'd0);
    chk("rst_su_A", {16'b0, bus.su_A}, 32'd0);
    chk("rst_su_fun", {30'b0, bus.su_fun}, 32'd0);
    chk("rst_su_B", {16'b0, bus.su_B}, 32'd0);
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].dr, vecs[i].c, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].el);
      chk($sformatf("v%0d_res_data", i), {16'b0, bus.res_data}, {16'b0, vecs[i].ed});
      chk($sformatf("v%0d_res_zero", i), {31'b0, bus.res_zero}, {31'b0, vecs[i].ez});
      chk($sformatf("v%0d_pulses", i), a_log.size(), vecs[i].el / 2);
      chk($sformatf("v%0d_su_B", i), {16'b0, bus.su_B}, 32'd0);
      a = vecs[i].d;
      for (int k = 0; k < a_log.size() && k < 16; k++) begin
        chk($sformatf("v%0d_su_A%0d", i, k), {16'b0, a_log[k]}, {16'b0, a});
        chk($sformatf("v%0d_su_fun%0d", i, k), {30'b0, f_log[k]}, {31'b0, vecs[i].dr});
        a = vecs[i].dr ? a << 1 : a >> 1;
      end
      ack();
      chk($sformatf("v%0d_res_valid_drop", i), {31'b0, bus.res_valid}, 32'd0);
    end
    // Back-pressure with a competing command held valid throughout
    send(16'h0003, 1'b1, 5'd2, lat);
    chk("bp_latency", lat, 4);
    @(negedge clk);
    bus.cmd_data  = 16'h0010;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 5'd1;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_res_data", {16'b0, bus.res_data}, 32'h000C);
      chk("bp_res_valid", {31'b0, bus.res_valid}, 32'd1);
      chk("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    a_log.delete();
    chk("bp_after_hs_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    chk("bp_second_accepted", {31'b0, bus.cmd_ready}, 32'd0);
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_second_latency", lat, 2);
    chk("bp_second_data", {16'b0, bus.res_data}, 32'h0008);
    chk("bp_second_pulses", a_log.size(), 1);
    ack();
    // Reset while waiting on the shift unit
    @(negedge clk);
    bus.cmd_data  = 16'h0100;
    bus.cmd_dir   = 1'b1;
    bus.cmd_count = 5'd8;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_su_enable", {31'b0, bus.su_enable}, 32'd0);
    chk("mid_wait_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("mid_rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("mid_rst_su_enable", {31'b0, bus.su_enable}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_result", {31'b0, bus.res_valid}, 32'd0);
    send(16'h0002, 1'b0, 5'd1, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_data", {16'b0, bus.res_data}, 32'h0001);
    chk("post_rst_pulses", a_log.size(), 1);
    ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-bit shift controller that sits directly upstream of the ALU's 1-bit registered shift unit and consumes its output. It accepts a shift command (operand, direction, count) over a valid/ready handshake. It iterates the shift unit once per bit, feeding each registered result back as the next operand. It presents the final value on a valid/ready result port. This gives the ALU arbitrary logical shifts of 0..WIDTH positions without widening the shift unit.

## Interface
- WIDTH, 16, data width; must equal the shift unit's width
- CNT_W, 5, width of the shift-count field; must satisfy 2^CNT_W > WIDTH
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset, sampled on rising clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_data  in  WIDTH  operand to shift
- cmd_dir  in  1  0 = logical right, 1 = logical left
- cmd_count  in  CNT_W  number of bit positions to shift
- su_A  out  WIDTH  operand to shift unit (current working value)
- su_B  out  WIDTH  tied to 0
- su_fun  out  2  shift unit function: {1'b0, dir}; 00 = A>>1, 01 = A<<1
- su_enable  out  1  one-cycle shift request to shift unit
- su_out  in  WIDTH  registered shift unit result
- su_flag  in  1  shift unit result valid (registered, one cycle after su_enable)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  WIDTH  shifted value
- res_zero  out  1  res_data == 0

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: work[WIDTH-1:0], cnt[CNT_W-1:0], dir.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch work=cmd_data and dir=cmd_dir.
  - Count clamp: cnt = min(cmd_count, WIDTH).
  - If the clamped count is 0, go to DONE. Otherwise go to ISSUE.
- ISSUE: su_enable=1, su_A=work, su_fun={0,dir}. Go to WAIT unconditionally.
- WAIT: su_enable=0.
  - If su_flag=1: work=su_out, cnt=cnt-1. Go to DONE if the new cnt is 0, else go to ISSUE.
  - If su_flag=0: hold in WAIT. This is a protocol error, not expected in normal use; no timeout.
- DONE: res_valid=1, res_data=work, res_zero=(work==0).
  - On res_ready, go to IDLE. Data and valid stay stable until the handshake completes.
- cmd_ready is 1 only in IDLE. cmd_valid in any other state is ignored and not buffered.
- su_A drives work in every state. su_fun drives {0,dir} in every state. Only su_enable qualifies a request.
- su_B is constant 0.
- Shifts are logical with zero fill. Clamped count WIDTH therefore always yields 0.

## Timing
- Reset values: state=IDLE, work=0, cnt=0, dir=0. Outputs:
  - cmd_ready=1 from the first cycle after reset release.
  - res_valid=0, res_data=0, res_zero=1.
  - su_enable=0, su_A=0, su_fun=00, su_B=0.
- Reset mid-operation (any state) returns to IDLE on that edge and abandons the command. No result is produced.
  - The shift unit shares reset. A su_flag arriving after reset is ignored because the sequencer is in IDLE.
- Latency: call the accept edge E0. Each bit costs 2 edges (ISSUE, WAIT).
  - res_valid is visible after edge E0+2N, where N is the clamped count.
  - N=0: res_valid is visible after E0 itself.
- Next command accept: no earlier than the edge after the result handshake edge. There is one IDLE cycle minimum between commands.
- Max occupancy per command: 2*WIDTH+2 cycles, excluding result back-pressure.
- res_valid high with res_ready low: hold indefinitely, no data change.

## Test plan
- Left shift: cmd_data=0x0001, dir=1, count=3. Response: res_data=0x0008, res_zero=0, res_valid after E0+6. Exactly 3 su_enable pulses, each with su_A = 0x0001, 0x0002, 0x0004.
- Right shift: cmd_data=0x8000, dir=0, count=15. Response: res_data=0x0001 after E0+30. Also count=0 with data 0xA5A5: res_data=0xA5A5 after E0, zero su_enable pulses.
- Clamp: cmd_data=0xFFFF, dir=1, count=20. Response: res_data=0x0000, res_zero=1, 16 su_enable pulses, res_valid after E0+32.
- Back-pressure/busy: hold res_ready=0 for 10 cycles and assert a second cmd_valid throughout.
  - res_data stays stable and cmd_ready stays 0.
  - The second command is accepted only on the edge after the res handshake.
- Reset mid-op: assert reset in the WAIT state of a count=8 command. Response:
  - Next cycle: IDLE, cmd_ready=1, res_valid=0, su_enable=0.
  - A new count=1 command on 0x0002 right returns 0x0001 after E0+2.
